rackctl_bidir_link: RTL

- Parametrised half-duplex transaction engine for the SURF RACKCTL single-wire LVDS link.
- Sends a preamble plus a DATA_BITS-wide command word, turns the line around, and waits for a framed response word from the TURFIO.
- Turns the line back around and reports the response or an error code.
- Replaces VIO-driven bring-up logic with a valid/ready command port. The IOBUFDS_DIFF_OUT stays in the parent; this block drives its I/T pins and takes the non-inverted O/OB pick.

---
 rtl/rackctl_bidir_link.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rackctl_bidir_link.sv
// rackctl_bidir_link: half-duplex command/response engine for the RACKCTL single-wire LVDS link.
// Sends preamble + command, turns the line around, captures a framed response, then turns it back.
module rackctl_bidir_link #(
  parameter int unsigned DATA_BITS       = 32,
  parameter int unsigned PREAMBLE_LEN    = 5,
  parameter logic [15:0] PREAMBLE        = 16'h0015,
  parameter int unsigned TURNAROUND_CLKS = 128,
  parameter int unsigned RESP_TIMEOUT    = 1024,
  parameter logic        INV             = 1'b0
) (
  input  logic                 sysclk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic                 busy_o,
  input  logic                 rackctl_in_i,
  output logic                 rackctl_out_o,
  output logic                 rackctl_tri_o
);

  localparam int unsigned MAX_DT  = (DATA_BITS > TURNAROUND_CLKS) ? DATA_BITS : TURNAROUND_CLKS;
  localparam int unsigned MAX_LEN = (MAX_DT > RESP_TIMEOUT) ? MAX_DT : RESP_TIMEOUT;
  localparam int unsigned CW      = $clog2(MAX_LEN) + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] TA_LAST  = CW'(TURNAROUND_CLKS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(RESP_TIMEOUT - 1);
  // Preamble left-justified so the first bit to send sits at bit 15.
  localparam logic [15:0]   PRE_ALIGNED = PREAMBLE << (16 - PREAMBLE_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DATA, S_TURN0, S_POST, S_START, S_CAPTURE, S_TURN1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_POSTAMBLE = 2'd1,
    ERR_TIMEOUT   = 2'd2
  } err_code_t;

  state_t                 state_q;
  err_code_t              err_code_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [15:0]            pre_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   err_q;
  logic                   in_q;
  logic                   out_q;
  logic                   tri_q;

  // NOTE: every register below is updated with <= so all of them see the same pre-edge values.
  always_ff @(posedge sysclk_i) begin
    in_q       <= rackctl_in_i;
    rx_valid_q <= 1'b0;
    err_q      <= 1'b0;
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      out_q      <= INV ^ 1'b1;
      tri_q      <= 1'b0;
      rx_data_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      // Pad registers follow the current state, so the pad lags each state entry by one clock.
      out_q <= INV ^ 1'b1;
      tri_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // NOTE: shift_q/pre_q carry no reset; they are always reloaded here before use.
          if (tx_valid_i) begin
            shift_q <= tx_data_i;
            pre_q   <= PRE_ALIGNED;
            cnt_q   <= '0;
            state_q <= S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          out_q <= INV ^ pre_q[15];
          pre_q <= pre_q << 1;
          if (cnt_q == PRE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          out_q   <= INV ^ shift_q[DATA_BITS-1];
          shift_q <= shift_q << 1;
          if (cnt_q == DAT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_TURN0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_TURN0: begin
          tri_q <= 1'b1;
          if (cnt_q == TA_LAST) begin
            cnt_q   <= '0;
            state_q <= S_POST;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_POST: begin
          tri_q <= 1'b1;
          cnt_q <= '0;
          if (in_q) begin
            state_q <= S_START;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= ERR_POSTAMBLE;
            state_q    <= S_TURN1;
          end
        end
        S_START: begin
          tri_q <= 1'b1;
          // A start bit on the final timeout clock still wins over the timeout.
          if (!in_q) begin
            cnt_q   <= '0;
            state_q <= S_CAPTURE;
          end else if (cnt_q == TO_LAST) begin
            cnt_q      <= '0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_TURN1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_CAPTURE: begin
          tri_q   <= 1'b1;
          shift_q <= {shift_q[DATA_BITS-2:0], in_q};
          if (cnt_q == DAT_LAST) begin
            cnt_q      <= '0;
            rx_data_q  <= {shift_q[DATA_BITS-2:0], in_q};
            rx_valid_q <= 1'b1;
            state_q    <= S_TURN1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_TURN1: begin
          if (cnt_q == TA_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o    = (state_q == S_IDLE) && !rst_i;
  assign busy_o        = (state_q != S_IDLE);
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign rackctl_out_o = out_q;
  assign rackctl_tri_o = tri_q;

endmodule
